// File: rtl/st_channel_packet_arbiter.sv
// Round-robin packet arbiter: merges NUM_IN Avalon-ST requesters onto one channelised stream,
// holding the grant for a whole SOP..EOP packet and discarding out-of-packet beats while idle.
module st_channel_packet_arbiter #(
    parameter int NUM_IN    = 4,
    parameter int DATA_W    = 8,
    parameter int CHANNEL_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_startofpacket,
    input  logic [NUM_IN-1:0]        in_endofpacket,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CHANNEL_W-1:0]     out_channel,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [15:0]              drop_count
);

    localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t            state;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     rr_ptr;

    logic [NUM_IN-1:0] sop_cand;
    logic [NUM_IN-1:0] drop_hit;
    logic              beat_ready;
    logic              beat_acc;
    logic [DATA_W-1:0] grant_data;

    // First requester at or after ptr, wrapping; ptr itself when nobody asks.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_IN-1:0] cand,
                                              input logic [GW-1:0]     ptr);
        logic [GW-1:0] sel;
        logic          found;
        int            idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = (int'(ptr) + k) % NUM_IN;
            if (!found && cand[idx]) begin
                sel   = idx[GW-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [GW-1:0] rr_next(input logic [GW-1:0] g);
        return (int'(g) == NUM_IN - 1) ? '0 : g + 1'b1;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0]     cnt,
                                            input logic [NUM_IN-1:0] hits);
        logic [16:0] sum;
        sum = {1'b0, cnt};
        for (int k = 0; k < NUM_IN; k++) begin
            sum = sum + {16'd0, hits[k]};
        end
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_comb begin
        sop_cand   = in_valid & in_startofpacket;
        drop_hit   = '0;
        in_ready   = '0;
        beat_ready = out_ready | ~out_valid;
        if (!reset) begin
            if (state == IDLE) begin
                drop_hit = in_valid & ~in_startofpacket;
                in_ready = drop_hit;
            end else begin
                in_ready[grant] = beat_ready;
            end
        end
        beat_acc   = (state == BUSY) && !reset && in_valid[grant] && beat_ready;
        grant_data = in_data[grant*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            grant             <= '0;
            rr_ptr            <= '0;
            drop_count        <= '0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_channel       <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
        end else begin
            drop_count <= sat_add(drop_count, drop_hit);

            case (state)
                IDLE: begin
                    if (|sop_cand) begin
                        grant <= rr_pick(sop_cand, rr_ptr);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (beat_acc && in_endofpacket[grant]) begin
                        state  <= IDLE;
                        rr_ptr <= rr_next(grant);
                    end
                end
                default: state <= IDLE;
            endcase

            // Output stage: one-deep register, payload frozen while downstream stalls.
            if (beat_acc) begin
                out_valid         <= 1'b1;
                out_data          <= grant_data;
                out_channel       <= CHANNEL_W'(grant);
                out_startofpacket <= in_startofpacket[grant];
                out_endofpacket   <= in_endofpacket[grant];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_st_channel_packet_arbiter.sv
// Bench for st_channel_packet_arbiter: directed scenarios plus a randomized run scored per channel.
module tb_st_channel_packet_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_valid, in_ready, in_sop, in_eop;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data, out_channel;
    logic        out_sop, out_eop;
    logic [15:0] drop_count;

    int ntests = 0, nfail = 0, cycnt = 0, first_ov = -1;

    logic [9:0]  src_q[4][$];
    logic [9:0]  exp_q[4][$];
    logic [17:0] log_q[$];
    logic [17:0] elog[$];
    logic        rnd_gaps = 1'b0, rnd_ready = 1'b0, gen_new = 1'b0;
    logic [3:0]  acc_s, ir_s;
    logic        ohs, stalled;
    logic [17:0] o_snap;
    logic [7:0]  owner;
    logic        owner_act = 1'b0;

    always #5 clk = ~clk;

    st_channel_packet_arbiter #(.NUM_IN(4), .DATA_W(8), .CHANNEL_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_channel(out_channel), .out_startofpacket(out_sop),
        .out_endofpacket(out_eop), .drop_count(drop_count)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] cur_out();
        return {out_channel, out_sop, out_eop, out_data};
    endfunction

    function automatic bit all_src_empty();
        for (int i = 0; i < 4; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clr_in();
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
    endtask

    task automatic push_pkt(input int r, input int len, input logic [7:0] base);
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            d = base + 8'(k);
            src_q[r].push_back({(k == 0), (k == len - 1), d});
        end
    endtask

    task automatic exp_pkt(input int ch, input int len, input logic [7:0] base);
        logic [7:0] d;
        for (int k = 0; k < len; k++) begin
            d = base + 8'(k);
            elog.push_back({8'(ch), (k == 0), (k == len - 1), d});
        end
    endtask

    // One clock: drive from the source queues, sample at negedge, account after the edge.
    task automatic cyc();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0 && (!rnd_gaps || $urandom_range(3) != 0)) begin
                in_valid[i]        = 1'b1;
                in_sop[i]          = src_q[i][0][9];
                in_eop[i]          = src_q[i][0][8];
                in_data[i*8 +: 8]  = src_q[i][0][7:0];
            end else begin
                in_valid[i]        = 1'b0;
                in_sop[i]          = 1'b0;
                in_eop[i]          = 1'b0;
                in_data[i*8 +: 8]  = 8'h00;
            end
        end
        if (rnd_ready) out_ready = 1'($urandom_range(1));
        @(negedge clk);
        acc_s   = in_valid & in_ready;
        ir_s    = in_ready;
        ohs     = out_valid & out_ready;
        stalled = out_valid & ~out_ready;
        o_snap  = cur_out();
        @(posedge clk);
        #1;
        cycnt++;
        for (int i = 0; i < 4; i++) begin
            if (acc_s[i]) begin
                exp_q[i].push_back(src_q[i][0]);
                src_q[i].delete(0);
            end
        end
        if (ohs) log_q.push_back(o_snap);
        if (stalled) chk("stall_hold", {13'd0, out_valid, cur_out()}, {13'd0, 1'b1, o_snap});
        if (out_valid && first_ov < 0) first_ov = cycnt;
    endtask

    task automatic run_until_idle(input int bound);
        int n;
        n = 0;
        while (!(all_src_empty() && !out_valid) && n < bound) begin
            cyc();
            n++;
        end
        chk("idle_reached", {31'd0, (all_src_empty() && !out_valid)}, 32'd1);
        clr_in();
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_len"}, log_q.size(), elog.size());
        for (int k = 0; k < elog.size() && k < log_q.size(); k++) chk(tag, log_q[k], elog[k]);
        log_q.delete();
        elog.delete();
    endtask

    task automatic sb_drain();
        logic [17:0] e;
        logic [7:0]  ch;
        logic [9:0]  x;
        while (log_q.size() > 0) begin
            e  = log_q.pop_front();
            ch = e[17:10];
            chk("rnd_chan_range", {31'd0, (ch < 8'd4)}, 32'd1);
            if (ch < 8'd4) begin
                chk("rnd_beat_expected", {31'd0, (exp_q[ch[1:0]].size() > 0)}, 32'd1);
                if (exp_q[ch[1:0]].size() > 0) begin
                    x = exp_q[ch[1:0]].pop_front();
                    chk("rnd_beat", {22'd0, e[9:0]}, {22'd0, x});
                end
            end
            if (owner_act) chk("rnd_no_interleave", {24'd0, ch}, {24'd0, owner});
            if (e[9]) begin owner = ch; owner_act = 1'b1; end
            if (e[8]) owner_act = 1'b0;
        end
    endtask

    initial begin
        int start;
        int rem[4];
        int ptr, sel, c;

        reset = 1'b1; clr_in(); out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 4'hF;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_channel", {24'd0, out_channel}, 32'd0);
        chk("rst_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
        clr_in();
        reset = 1'b0;

        // Rotation: every requester holds single-beat packets.
        for (int i = 0; i < 4; i++) begin
            rem[i] = 3;
            for (int k = 0; k < 3; k++) src_q[i].push_back({1'b1, 1'b1, 8'(8'h40 + i*16 + k)});
        end
        ptr = 0;
        for (int p = 0; p < 12; p++) begin
            sel = -1;
            for (int k = 0; k < 4; k++) begin
                c = (ptr + k) % 4;
                if (sel < 0 && rem[c] > 0) sel = c;
            end
            elog.push_back({8'(sel), 1'b1, 1'b1, 8'(8'h40 + sel*16 + (3 - rem[sel]))});
            rem[sel]--;
            ptr = (sel + 1) % 4;
        end
        run_until_idle(200);
        cmp_log("rotation");

        // Three-beat packet from requester 2, latency from first valid.
        first_ov = -1;
        start = cycnt;
        src_q[2].push_back({1'b1, 1'b0, 8'h11});
        src_q[2].push_back({1'b0, 1'b0, 8'h22});
        src_q[2].push_back({1'b0, 1'b1, 8'h33});
        elog.push_back({8'd2, 1'b1, 1'b0, 8'h11});
        elog.push_back({8'd2, 1'b0, 1'b0, 8'h22});
        elog.push_back({8'd2, 1'b0, 1'b1, 8'h33});
        run_until_idle(50);
        chk("latency_first_valid", first_ov - start, 32'd2);
        cmp_log("three_beat");

        // Downstream stall in the middle of requester 1's packet; requester 0 waits.
        push_pkt(1, 4, 8'hA0);
        cyc();
        cyc();
        push_pkt(0, 2, 8'hC0);
        out_ready = 1'b0;
        repeat (5) begin
            cyc();
            chk("stall_in_ready1", {31'd0, ir_s[1]}, 32'd0);
        end
        chk("stall_data", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA0});
        out_ready = 1'b1;
        run_until_idle(100);
        exp_pkt(1, 4, 8'hA0);
        exp_pkt(0, 2, 8'hC0);
        cmp_log("stall");

        // Out-of-packet beats while idle are dropped and counted.
        chk("drop_before", {16'd0, drop_count}, 32'd0);
        first_ov = -1;
        for (int k = 0; k < 3; k++) src_q[3].push_back({1'b0, 1'b0, 8'(8'h70 + k)});
        run_until_idle(20);
        chk("drop_count3", {16'd0, drop_count}, 32'd3);
        chk("drop_no_out_valid", first_ov, -1);
        chk("drop_log_empty", log_q.size(), 0);

        // Drive the counter to and across saturation.
        in_valid = 4'hF; in_sop = 4'h0;
        repeat (16382) @(posedge clk);
        #1;
        chk("drop_pre_sat", {16'd0, drop_count}, 32'h0000FFFB);
        in_valid = 4'b0111;
        @(posedge clk); #1;
        chk("drop_fffe", {16'd0, drop_count}, 32'h0000FFFE);
        @(posedge clk); #1;
        chk("drop_sat_cross", {16'd0, drop_count}, 32'h0000FFFF);
        in_valid = 4'hF;
        repeat (20) @(posedge clk);
        #1;
        chk("drop_sat_hold", {16'd0, drop_count}, 32'h0000FFFF);
        clr_in();

        // Reset in the middle of a four-beat packet.
        push_pkt(2, 4, 8'h50);
        cyc(); cyc(); cyc();
        chk("mid_pkt_beat1", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h51});
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", {24'd0, out_data}, 32'd0);
        chk("midrst_out_channel", {24'd0, out_channel}, 32'd0);
        chk("midrst_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
        chk("midrst_drop", {16'd0, drop_count}, 32'd0);
        chk("midrst_in_ready", {28'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clr_in();
        for (int i = 0; i < 4; i++) begin src_q[i].delete(); exp_q[i].delete(); end
        log_q.delete();
        push_pkt(1, 1, 8'h61);
        push_pkt(0, 1, 8'h60);
        run_until_idle(50);
        exp_pkt(0, 1, 8'h60);
        exp_pkt(1, 1, 8'h61);
        cmp_log("post_reset");

        // Randomized traffic with valid gaps and random backpressure.
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        log_q.delete();
        owner_act = 1'b0;
        gen_new = 1'b1; rnd_gaps = 1'b1; rnd_ready = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (gen_new && src_q[i].size() == 0 && $urandom_range(3) == 0)
                    push_pkt(i, int'($urandom_range(4, 1)), 8'($urandom));
            end
            cyc();
            sb_drain();
        end
        gen_new = 1'b0; rnd_gaps = 1'b0; rnd_ready = 1'b0; out_ready = 1'b1;
        run_until_idle(500);
        sb_drain();
        for (int i = 0; i < 4; i++) chk("rnd_drained", exp_q[i].size(), 0);
        chk("rnd_owner_closed", {31'd0, owner_act}, 32'd0);
        chk("rnd_no_drops", {16'd0, drop_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
